// File: rtl/matmul_pkg.sv
// Shared matrix-multiply constants, readout FSM encodings and the FIFO payload type.
package matmul_pkg;

   localparam int unsigned DATA_W = 22;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned N_LOG2 = 6;

   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rd_entry_t;

endpackage

// File: rtl/matc_readout_if.sv
// Result stream from the C readout to its consumer (valid/ready, row-major).
interface matc_readout_if;
   import matmul_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [N_LOG2-1:0] out_row;
   logic [N_LOG2-1:0] out_col;
   logic              out_last;

   modport master (output out_valid, out_data, out_row, out_col, out_last,
                   input  out_ready);
   modport slave  (input  out_valid, out_data, out_row, out_col, out_last,
                   output out_ready);

endinterface

// File: rtl/matc_readout_result_skid_fifo.sv
// Two-entry FIFO of {addr, data}; head entry is held in its own register.
module result_skid_fifo
   import matmul_pkg::*;
(
   input  logic      clk,
   input  logic      rstn,
   input  logic      push,
   input  logic      pop,
   input  rd_entry_t din,
   output logic [1:0] count,
   output rd_entry_t head
);

   rd_entry_t tail_q;

   // Producer never pushes into a full FIFO; pop is only raised when non-empty.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         count  <= 2'd0;
         head   <= '0;
         tail_q <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= din;
               else               tail_q <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail_q;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= din;
               end else begin
                  head   <= tail_q;
                  tail_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/matc_readout.sv
// Drains the 64x64 C result memory in row-major order onto a valid/ready stream.
module matc_readout
   import matmul_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-3:0]   mem_row,
   output logic [1:0]          mem_col,
   output logic                mem_nce,
   output logic                mem_nwrt,
   input  logic [DATA_W-1:0]   mem_q,
   matc_readout_if.master      out_if
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, tag_q;
   logic              inflight_q;
   logic              issue, pop, busy_d, done_d;
   logic [1:0]        fifo_count;
   rd_entry_t         fifo_head, push_entry;

   // Issue decision looks at this cycle's pop so a full stream needs no bubbles.
   assign pop   = out_if.out_valid & out_if.out_ready;
   assign issue = (state_q == ST_RUN) &&
                  ((3'(fifo_count) + 3'(inflight_q) - 3'(pop)) < 3'd2);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               if (cnt_q == ADDR_LAST) state_d = ST_FLUSH;
               else                    cnt_d   = cnt_q + ADDR_W'(1);
            end
         end
         ST_FLUSH: begin
            if (!inflight_q && ((3'(fifo_count) - 3'(pop)) == 3'd0)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inflight_q <= issue;
         if (issue) tag_q <= cnt_q;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   assign mem_nce    = ~issue;
   assign mem_nwrt   = 1'b1;
   assign mem_row    = cnt_q[ADDR_W-1:2];
   assign mem_col    = cnt_q[1:0];
   assign push_entry = {tag_q, mem_q};

   result_skid_fifo u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (inflight_q),
      .pop   (pop),
      .din   (push_entry),
      .count (fifo_count),
      .head  (fifo_head)
   );

   assign out_if.out_valid = (fifo_count != 2'd0);
   assign out_if.out_data  = fifo_head.data;
   assign out_if.out_row   = fifo_head.addr[ADDR_W-1:N_LOG2];
   assign out_if.out_col   = fifo_head.addr[N_LOG2-1:0];
   assign out_if.out_last  = out_if.out_valid && (fifo_head.addr == ADDR_LAST);

endmodule

// File: tb/tb_matc_readout.sv
// Self-checking bench for matc_readout: memory model, stream scoreboard, directed scenarios.
module tb_matc_readout;
   import matmul_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic busy, done, mem_nce, mem_nwrt;
   logic [ADDR_W-3:0] mem_row;
   logic [1:0]        mem_col;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] mem [4096];

   matc_readout_if bus();

   int checks = 0, failures = 0;
   int cyc = 0;
   int ready_mode = 0;
   int exp_addr = 0, issued = 0, accepted = 0, dones = 0;
   bit lit_on = 1'b0;
   bit prev_stall = 1'b0;
   logic [63:0] prev_word = '0;

   matc_readout dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .mem_row  (mem_row),
      .mem_col  (mem_col),
      .mem_nce  (mem_nce),
      .mem_nwrt (mem_nwrt),
      .mem_q    (mem_q),
      .out_if   (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read C memory: data one cycle after the sampled address.
   always @(posedge clk) if (mem_nce == 1'b0) mem_q <= mem[{mem_row, mem_col}];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] exp_word(input int a);
      logic [11:0] ad;
      ad = 12'(a);
      return {29'd0, mem[a], ad[11:6], ad[5:0], ad == 12'hFFF};
   endfunction

   function automatic logic [63:0] act_word();
      return {29'd0, bus.out_data, bus.out_row, bus.out_col, bus.out_last};
   endfunction

   // Consumer ready pattern.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(99) < 30);
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Scoreboard: expected stream is addresses 0..4095 in order with C[a].
   initial forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
         exp_addr = 0; issued = 0; accepted = 0; prev_stall = 1'b0;
      end else begin
         chk("mem_nwrt", 64'(mem_nwrt), 64'd1);
         if (prev_stall) chk("stall_hold", bus.out_valid ? act_word() : 64'hDEAD, prev_word);
         if (mem_nce === 1'b0) begin
            chk("issue_addr", 64'({mem_row, mem_col}), 64'(issued));
            chk("issue_busy", 64'(busy), 64'd1);
            issued++;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_addr > 4095) chk("extra_word", 64'(exp_addr), 64'd4095);
            else                 chk("word", act_word(), exp_word(exp_addr));
            if (lit_on && exp_addr == 0)
               chk("lit_w0", act_word(), 64'({22'd0, 6'd0, 6'd0, 1'b0}));
            if (lit_on && exp_addr == 65)
               chk("lit_w65", act_word(), 64'({22'd195, 6'd1, 6'd1, 1'b0}));
            if (lit_on && exp_addr == 4095)
               chk("lit_w4095", act_word(), 64'({22'd12285, 6'd63, 6'd63, 1'b1}));
            exp_addr++;
            accepted++;
         end
         if (busy === 1'b1) chk("outstanding_le2", 64'((issued - accepted) <= 2), 64'd1);
         prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
         prev_word  = act_word();
         if (done === 1'b1) begin
            chk("done_words", 64'(exp_addr), 64'd4096);
            chk("done_idle", 64'({busy, bus.out_valid}), 64'd0);
            dones++;
            exp_addr = 0; issued = 0; accepted = 0;
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_busy"},     64'(busy),          64'd0);
      chk({tag, "_done"},     64'(done),          64'd0);
      chk({tag, "_valid"},    64'(bus.out_valid), 64'd0);
      chk({tag, "_last"},     64'(bus.out_last),  64'd0);
      chk({tag, "_nce"},      64'(mem_nce),       64'd1);
      chk({tag, "_mem_addr"}, 64'({mem_row, mem_col}), 64'd0);
      chk({tag, "_data"},     64'(bus.out_data),  64'd0);
      chk({tag, "_rowcol"},   64'({bus.out_row, bus.out_col}), 64'd0);
   endtask

   task automatic pulse_start(output int t0);
      @(posedge clk);
      #1;
      start = 1'b1;
      t0 = cyc + 1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      bit got;
      got = 1'b0;
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1'b1;
            dcyc = cyc;
            break;
         end
      end
      chk("done_seen", 64'(got), 64'd1);
   endtask

   task automatic wait_addr(input int target, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_addr >= target) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_addr", 64'(ok), 64'd1);
   endtask

   initial begin
      int t0, dcyc, d0;
      for (int a = 0; a < 4096; a++) mem[a] = 22'(a * 3);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("init");
      @(posedge clk);
      #1 rstn = 1'b1;

      // Full-rate drain of C[a] = 3a, then start during DONE is ignored.
      ready_mode = 0;
      lit_on = 1'b1;
      pulse_start(t0);
      @(negedge clk);
      chk("t0p1_issue", 64'({busy, mem_nce, bus.out_valid}), 64'({1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      chk("t0p2_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("t0p3_valid", 64'(bus.out_valid), 64'd1);
      wait_done(4300, dcyc);
      chk("done_latency", 64'(dcyc - t0), 64'd4098);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lit_on = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("start_in_done_ignored", 64'({busy, mem_nce}), 64'({1'b0, 1'b1}));
      end

      // Random backpressure on random contents.
      for (int a = 0; a < 4096; a++) mem[a] = 22'($urandom);
      ready_mode = 1;
      pulse_start(t0);
      wait_done(20000, dcyc);
      chk("dones_after_random", 64'(dones), 64'd2);

      // Long stall right after start.
      ready_mode = 2;
      pulse_start(t0);
      repeat (100) @(negedge clk);
      chk("stall_issued", 64'(issued), 64'd2);
      chk("stall_valid", 64'({bus.out_valid, mem_nce}), 64'({1'b1, 1'b1}));
      chk("stall_head", 64'({bus.out_data, bus.out_row, bus.out_col}), 64'({mem[0], 12'd0}));
      ready_mode = 0;
      @(posedge clk);
      #2;
      repeat (300) begin
         @(negedge clk);
         chk("no_gap", 64'(bus.out_valid), 64'd1);
      end
      wait_done(4300, dcyc);

      // Start while busy is ignored.
      ready_mode = 1;
      d0 = dones;
      pulse_start(t0);
      wait_addr(1000, 5000);
      pulse_start(t0);
      wait_done(20000, dcyc);
      repeat (6) @(negedge clk);
      chk("single_done", 64'(dones), 64'(d0 + 1));
      chk("idle_after", 64'(busy), 64'd0);

      // Reset mid-transfer, then a fresh run from address 0.
      ready_mode = 0;
      d0 = dones;
      pulse_start(t0);
      wait_addr(2000, 3000);
      @(posedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset("midrst");
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_done_on_reset", 64'(dones), 64'(d0));
      pulse_start(t0);
      wait_done(4300, dcyc);
      chk("rerun_latency", 64'(dcyc - t0), 64'd4098);
      chk("rerun_dones", 64'(dones), 64'(d0 + 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
